// File: rtl/sram_pkg.sv
// sram_pkg: shared constants, state encoding and byte-merge helper for the
// dual-port byte-enable data memory.
//   RD_FIRST / WR_FIRST : collision modes (WR_MODE parameter values)
//   state_t             : clear sequencer states
//   be_merge()          : byte-enable merge, evaluated at MAX_D width; callers
//                         cast the result down to their own word width
package sram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Widest word the merge helper supports.
  localparam int MAX_D = 1024;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  // Byte k of the result comes from new_w when be[k] is set, else from old_w.
  function automatic logic [MAX_D-1:0] be_merge(input logic [MAX_D-1:0]   old_w,
                                                input logic [MAX_D-1:0]   new_w,
                                                input logic [MAX_D/8-1:0] be);
    logic [MAX_D-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_D/8; k++)
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: read-return pipeline for one memory port.
//   clk, rst : clock, synchronous active-high reset (flushes all stages)
//   req      : read accepted this cycle
//   din      : word read (already collision-resolved) for that request
//   valid    : dout holds read data this cycle
//   dout     : read data, zero when no read is in flight
// Stage 0 captures at the request edge, so data shows up after RD_LAT edges.
module sram_rd_pipe #(
  parameter int D_SIZE = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [D_SIZE-1:0] din,
  output logic              valid,
  output logic [D_SIZE-1:0] dout
);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("sram_rd_pipe: RD_LAT must be 1 or 2");
  end

  logic [RD_LAT-1:0]             vld_pipe;
  logic [RD_LAT-1:0][D_SIZE-1:0] dat_pipe;

  // Idle slots carry zero data so the output is never a stale word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[0] <= 1'b0;
      dat_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= req;
      dat_pipe[0] <= req ? din : '0;
    end
  end

  for (genvar g = 1; g < RD_LAT; g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe[g] <= 1'b0;
        dat_pipe[g] <= '0;
      end else begin
        vld_pipe[g] <= vld_pipe[g-1];
        dat_pipe[g] <= dat_pipe[g-1];
      end
    end
  end

  assign valid = vld_pipe[RD_LAT-1];
  assign dout  = dat_pipe[RD_LAT-1];

endmodule

// File: rtl/sram_dp_be.sv
// sram_dp_be: data memory, port A read/write with byte enables, port B read-only.
//   clk, rst              : clock, synchronous active-high reset
//   ready                 : accepting requests (post-reset clear finished)
//   a_read/a_write/a_be   : port A request controls
//   a_address/a_data_in   : port A address and write data
//   a_data_out/a_valid    : port A read return
//   b_read/b_address      : port B read request
//   b_data_out/b_valid    : port B read return
// After reset the array is swept to zero one word per cycle rather than reset
// in place, which keeps it mappable to block RAM.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int D_SIZE       = 32,
  parameter int A_SIZE       = 10,
  parameter int RD_LAT       = 1,
  parameter int WR_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [D_SIZE/8-1:0] a_be,
  input  logic [A_SIZE-1:0]   a_address,
  input  logic [D_SIZE-1:0]   a_data_in,
  output logic [D_SIZE-1:0]   a_data_out,
  output logic                a_valid,
  input  logic                b_read,
  input  logic [A_SIZE-1:0]   b_address,
  output logic [D_SIZE-1:0]   b_data_out,
  output logic                b_valid
);

  localparam int DEPTH = 1 << A_SIZE;
  localparam int BE_W  = D_SIZE / 8;

  if (D_SIZE % 8 != 0 || D_SIZE > MAX_D) begin : g_bad_dsize
    $error("sram_dp_be: D_SIZE must be a multiple of 8 and <= MAX_D");
  end

  logic [D_SIZE-1:0] mem [DEPTH];

  state_t            state;
  logic [A_SIZE-1:0] clr_cnt;

  // ready is only set in S_READY, so it doubles as the request gate.
  logic a_wr_en, a_rd_en, b_rd_en;
  assign a_wr_en = ready & a_write;
  assign a_rd_en = ready & a_read;
  assign b_rd_en = ready & b_read;

  // Clear sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == A_SIZE'(DEPTH - 1)) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  // Single write port shared by the clear sweep and port A.
  logic              wr_en;
  logic [A_SIZE-1:0] wr_addr;
  logic [D_SIZE-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a_address;
    wr_data = a_data_in;
    wr_be   = a_be;
    if (!rst) begin
      if (state == S_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
        wr_be   = '1;
      end else begin
        wr_en = a_wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int k = 0; k < BE_W; k++)
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
  end

  // Read words with collision handling. The array read sees pre-edge contents,
  // which is read-first; write-first substitutes the merged word instead.
  logic [D_SIZE-1:0] a_old, a_new, a_rd_data;
  logic [D_SIZE-1:0] b_old, b_new, b_rd_data;

  assign a_old = mem[a_address];
  assign b_old = mem[b_address];
  assign a_new = D_SIZE'(be_merge(MAX_D'(a_old), MAX_D'(a_data_in), (MAX_D/8)'(a_be)));
  assign b_new = D_SIZE'(be_merge(MAX_D'(b_old), MAX_D'(a_data_in), (MAX_D/8)'(a_be)));

  assign a_rd_data = (WR_MODE == WR_FIRST && a_wr_en) ? a_new : a_old;
  assign b_rd_data = (WR_MODE == WR_FIRST && a_wr_en && b_address == a_address)
                   ? b_new : b_old;

  sram_rd_pipe #(.D_SIZE(D_SIZE), .RD_LAT(RD_LAT)) u_a_pipe (
    .clk   (clk),
    .rst   (rst),
    .req   (a_rd_en),
    .din   (a_rd_data),
    .valid (a_valid),
    .dout  (a_data_out)
  );

  sram_rd_pipe #(.D_SIZE(D_SIZE), .RD_LAT(RD_LAT)) u_b_pipe (
    .clk   (clk),
    .rst   (rst),
    .req   (b_rd_en),
    .din   (b_rd_data),
    .valid (b_valid),
    .dout  (b_data_out)
  );

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench: three instances share one stimulus stream.
//   u_rf : RD_LAT=1, read-first,  clear on reset
//   u_wf : RD_LAT=2, write-first, clear on reset
//   u_nc : RD_LAT=1, read-first,  no clear
module tb_sram_dp_be;
  localparam int D = 32;
  localparam int A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, a_read, a_write, b_read;
  logic [D/8-1:0] a_be;
  logic [A-1:0] a_address, b_address;
  logic [D-1:0] a_data_in;

  logic         rf_ready, rf_av, rf_bv, wf_ready, wf_av, wf_bv, nc_ready, nc_av, nc_bv;
  logic [D-1:0] rf_ad, rf_bd, wf_ad, wf_bd, nc_ad, nc_bd;

  sram_dp_be #(.D_SIZE(D), .A_SIZE(A), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RST(1)) u_rf (
    .clk(clk), .rst(rst), .ready(rf_ready), .a_read(a_read), .a_write(a_write),
    .a_be(a_be), .a_address(a_address), .a_data_in(a_data_in), .a_data_out(rf_ad),
    .a_valid(rf_av), .b_read(b_read), .b_address(b_address), .b_data_out(rf_bd),
    .b_valid(rf_bv));

  sram_dp_be #(.D_SIZE(D), .A_SIZE(A), .RD_LAT(2), .WR_MODE(1), .CLEAR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst), .ready(wf_ready), .a_read(a_read), .a_write(a_write),
    .a_be(a_be), .a_address(a_address), .a_data_in(a_data_in), .a_data_out(wf_ad),
    .a_valid(wf_av), .b_read(b_read), .b_address(b_address), .b_data_out(wf_bd),
    .b_valid(wf_bv));

  sram_dp_be #(.D_SIZE(D), .A_SIZE(A), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RST(0)) u_nc (
    .clk(clk), .rst(rst), .ready(nc_ready), .a_read(a_read), .a_write(a_write),
    .a_be(a_be), .a_address(a_address), .a_data_in(a_data_in), .a_data_out(nc_ad),
    .a_valid(nc_av), .b_read(b_read), .b_address(b_address), .b_data_out(nc_bd),
    .b_valid(nc_bv));

  int checks = 0;
  int errors = 0;
  int cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_read = 0; a_write = 0; b_read = 0;
  endtask

  task automatic wr(input logic [A-1:0] ad, input logic [D-1:0] d, input logic [3:0] be);
    a_write = 1; a_address = ad; a_data_in = d; a_be = be;
    tick();
    a_write = 0;
  endtask

  initial begin
    rst = 1; idle(); a_be = '0; a_address = '0; b_address = '0; a_data_in = '0;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 32'(rf_ready), 32'd0);
    chk("rst_a_valid", 32'(rf_av), 32'd0);
    chk("rst_a_data", rf_ad, 32'd0);
    chk("rst_wf_b_valid", 32'(wf_bv), 32'd0);

    // clear takes DEPTH cycles; no-clear instance is ready after one
    rst = 0;
    cnt = 0;
    while (!rf_ready && cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 1) begin
        chk("nc_ready", 32'(nc_ready), 32'd1);
        chk("nc_idle_av", 32'(nc_av), 32'd0);
        chk("nc_idle_ad", nc_ad, 32'd0);
        chk("nc_idle_bv", 32'(nc_bv), 32'd0);
        chk("nc_idle_bd", nc_bd, 32'd0);
      end
    end
    chk("clear_cycles", 32'(cnt), 32'd16);
    chk("wf_ready", 32'(wf_ready), 32'd1);

    // cleared word reads zero
    a_read = 1; a_address = 5;
    tick(); a_read = 0;
    chk("clr5_av", 32'(rf_av), 32'd1);
    chk("clr5_ad", rf_ad, 32'd0);

    // byte-enable merge
    wr(3, 32'hAABBCCDD, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    a_read = 1; a_address = 3;
    tick(); a_read = 0;
    chk("be_rf_av", 32'(rf_av), 32'd1);
    chk("be_rf_ad", rf_ad, 32'hAA22CC44);
    chk("be_wf_av_early", 32'(wf_av), 32'd0);
    tick();
    chk("be_rf_ad_idle", rf_ad, 32'd0);
    chk("be_rf_av_idle", 32'(rf_av), 32'd0);
    chk("be_wf_av", 32'(wf_av), 32'd1);
    chk("be_wf_ad", wf_ad, 32'hAA22CC44);

    // be=0 write leaves the word alone
    wr(1, 32'h00000101, 4'b1111);
    wr(1, 32'hFFFFFFFF, 4'b0000);
    wr(2, 32'h00000202, 4'b1111);

    // port B collision with port A write
    wr(7, 32'h1, 4'b1111);
    a_write = 1; a_address = 7; a_data_in = 32'h2; a_be = 4'b1111;
    b_read = 1; b_address = 7;
    tick(); idle();
    chk("colb_rf_bv", 32'(rf_bv), 32'd1);
    chk("colb_rf_bd", rf_bd, 32'h1);
    tick();
    chk("colb_wf_bv", 32'(wf_bv), 32'd1);
    chk("colb_wf_bd", wf_bd, 32'h2);
    chk("colb_rf_bd_idle", rf_bd, 32'd0);

    // port A read+write same cycle
    a_write = 1; a_read = 1; a_address = 3; a_data_in = 32'h0; a_be = 4'b1000;
    tick(); idle();
    chk("cola_rf_ad", rf_ad, 32'hAA22CC44);
    tick();
    chk("cola_wf_ad", wf_ad, 32'h0022CC44);

    // back-to-back reads @1,@2,@3
    a_read = 1; a_address = 1;
    tick();
    chk("b2b_rf_1", rf_ad, 32'h101);
    chk("b2b_wf_v0", 32'(wf_av), 32'd0);
    a_address = 2;
    tick();
    chk("b2b_rf_2", rf_ad, 32'h202);
    chk("b2b_wf_1", wf_ad, 32'h101);
    chk("b2b_wf_v1", 32'(wf_av), 32'd1);
    a_address = 3;
    tick(); a_read = 0;
    chk("b2b_rf_3", rf_ad, 32'h0022CC44);
    chk("b2b_wf_2", wf_ad, 32'h202);
    chk("b2b_wf_v2", 32'(wf_av), 32'd1);
    tick();
    chk("b2b_rf_idle", rf_ad, 32'd0);
    chk("b2b_wf_3", wf_ad, 32'h0022CC44);
    chk("b2b_wf_v3", 32'(wf_av), 32'd1);
    tick();
    chk("b2b_wf_idle_v", 32'(wf_av), 32'd0);
    chk("b2b_wf_idle_d", wf_ad, 32'd0);

    // reset in the middle of clear, with requests hammering port A
    rst = 1; tick(); rst = 0;
    a_write = 1; a_read = 1; a_address = 0; a_data_in = 32'hDEADBEEF; a_be = 4'b1111;
    repeat (6) tick();
    rst = 1; tick(); rst = 0;
    cnt = 0;
    while (!rf_ready && cnt < 40) begin
      tick();
      cnt++;
      chk("clr2_av", 32'(rf_av), 32'd0);
    end
    idle();
    chk("clear2_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      a_read = 1; a_address = A'(i);
      b_read = 1; b_address = A'(15 - i);
      tick();
      chk($sformatf("zero_a%0d", i), rf_ad, 32'd0);
      chk($sformatf("zero_av%0d", i), 32'(rf_av), 32'd1);
      chk($sformatf("zero_b%0d", 15 - i), rf_bd, 32'd0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
